// File: rtl/branch_resolve_queue_pkg.sv
// Shared entry layout and commit-time helpers for the branch resolve queue.
// Both helpers work on one queue entry.
package brq_pkg;

  localparam int BRQ_DEPTH_DEF = 8;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        act_taken;
    logic [31:0] act_target;
  } brq_entry_t;

  // The predicted target only matters when the branch was actually taken.
  function automatic logic is_mispredict(input brq_entry_t e);
    return (e.pred_taken != e.act_taken) ||
           (e.act_taken && (e.pred_target != e.act_target));
  endfunction

  function automatic logic [31:0] redirect_of(input brq_entry_t e);
    return e.act_taken ? e.act_target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/branch-FU/predictor-update signal bundle of the branch resolve queue.
// Handshake: an alloc is accepted in a cycle where alloc_valid && alloc_ready; resolve has no back-pressure.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 8
) ();
  localparam int TAG_W = $clog2(DEPTH);

  logic             alloc_valid;
  logic             alloc_ready;
  logic [31:0]      alloc_pc;
  logic             alloc_pred_taken;
  logic [31:0]      alloc_pred_target;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [TAG_W:0]   count;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    output res_valid, res_tag, res_taken, res_target,
    input  alloc_ready, alloc_tag, upd_valid, upd_pc, upd_taken,
    input  flush, redirect_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
    input  res_valid, res_tag, res_taken, res_target,
    output alloc_ready, alloc_tag, upd_valid, upd_pc, upd_taken,
    output flush, redirect_pc, count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branches: allocated by fetch, resolved out of order
// by the branch FU, committed from the head into the predictor update port.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH_DEF
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_queue_if.slave brq
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int PW    = TAG_W + 1;

  brq_entry_t       ent_q [DEPTH];
  brq_entry_t       ent_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic             upd_valid_q, upd_valid_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  brq_entry_t       head_e;
  brq_entry_t       res_e;
  logic             full;
  logic             commit;
  logic             commit_mp;
  logic             alloc_fire;
  logic             res_fire;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign head_e   = ent_q[head_idx];
  assign res_e    = ent_q[brq.res_tag];

  assign full      = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign commit    = head_e.valid && head_e.resolved;
  assign commit_mp = commit && is_mispredict(head_e);

  // No bypass: a commit this cycle never makes room for an alloc into a full queue.
  assign brq.alloc_ready = !full && !commit_mp;
  assign alloc_fire      = brq.alloc_valid && brq.alloc_ready;
  assign res_fire        = brq.res_valid && res_e.valid && !res_e.resolved && !commit_mp;

  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    upd_valid_d = commit;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    flush_d     = commit_mp;
    redirect_d  = redirect_q;

    if (commit) begin
      upd_pc_d    = head_e.pc;
      upd_taken_d = head_e.act_taken;
      redirect_d  = redirect_of(head_e);
    end

    if (commit_mp) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid    = 1'b0;
        ent_d[i].resolved = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit) begin
        ent_d[head_idx].valid    = 1'b0;
        ent_d[head_idx].resolved = 1'b0;
        head_d = head_q + PW'(1);
      end
      if (res_fire) begin
        ent_d[brq.res_tag].resolved   = 1'b1;
        ent_d[brq.res_tag].act_taken  = brq.res_taken;
        ent_d[brq.res_tag].act_target = brq.res_target;
      end
      if (alloc_fire) begin
        ent_d[tail_idx].valid       = 1'b1;
        ent_d[tail_idx].resolved    = 1'b0;
        ent_d[tail_idx].pc          = brq.alloc_pc;
        ent_d[tail_idx].pred_taken  = brq.alloc_pred_taken;
        ent_d[tail_idx].pred_target = brq.alloc_pred_target;
        ent_d[tail_idx].act_taken   = 1'b0;
        ent_d[tail_idx].act_target  = '0;
        tail_d = tail_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q      <= head_d;
      tail_q      <= tail_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
    end
  end

  assign brq.alloc_tag   = tail_idx;
  assign brq.count       = tail_q - head_q;
  assign brq.upd_valid   = upd_valid_q;
  assign brq.upd_pc      = upd_pc_q;
  assign brq.upd_taken   = upd_taken_q;
  assign brq.flush       = flush_q;
  assign brq.redirect_pc = redirect_q;

endmodule
